fetch_unit: RTL

Parametrised instruction-fetch stage for the pipelined CPU. It owns the program counter, issues reads to a synchronous instruction memory, buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, and hands them to decode over a valid/ready handshake. It adds back-pressure from decode and branch redirect with flush, which the existing fetch path lacks.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues reads to a synchronous
// instruction memory. Returned words are buffered with their PCs in a
// DEPTH-entry prefetch queue, then handed to decode over valid/ready.
// A redirect flushes the queue and reloads the PC.
module fetch_unit #(
    parameter int unsigned     PC_W     = 8,
    parameter int unsigned     INSTR_W  = 16,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_STEP  = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       redirect,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    req_pc;
    logic               inflight;
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [CW-1:0]      count;

    logic               pop;
    logic               push;
    logic [OW-1:0]      committed;
    logic               credit_ok;

    // Handshake, credit check and head-of-queue output decode
    always_comb begin
        out_valid  = (count != '0);
        pop        = out_valid & out_ready;
        push       = inflight & ~redirect;
        // Entries the queue must still hold once this cycle's pop leaves and
        // the in-flight word lands; pop implies count>=1, so no underflow.
        committed  = OW'(count) + OW'(inflight) - OW'(pop);
        credit_ok  = (committed < OW'(DEPTH));
        imem_req   = reset & ~redirect & credit_ok;
        imem_addr  = pc;
        fifo_count = count;
        out_instr  = out_valid ? instr_mem[rd_ptr] : '0;
        out_pc     = out_valid ? pc_mem[rd_ptr]    : '0;
    end

    // PC, in-flight tracking, queue pointers and occupancy; redirect wins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            // A coincident pop is simply absorbed by the flush.
            pc       <= redirect_pc;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (imem_req) begin
                req_pc   <= pc;
                pc       <= pc + PC_W'(PC_STEP);
                inflight <= 1'b1;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

    // Queue storage; contents are masked by out_valid so no reset is needed
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= req_pc;
        end
    end

endmodule
